// File: rtl/compare_event_fsm_pkg.sv
// compare_event_fsm_pkg: state encodings, default run-lengths and the comparator one-hot check.
package compare_event_fsm_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ALARM     = 2'd2,
        RELEASING = 2'd3
    } state_t;
    localparam int HOLD_DEF    = 4;
    localparam int RELEASE_DEF = 2;
    function automatic logic one_hot3(input logic g, input logic e, input logic l);
        return ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) || ({g, e, l} == 3'b001);
    endfunction
endpackage

// File: rtl/compare_event_if.sv
// compare_event_if: comparator result inputs and alarm/event outputs of compare_event_fsm.
interface compare_event_if #(parameter int CNT_W = 8);
    logic             in_valid;
    logic             greater;
    logic             equal;
    logic             lesser;
    logic             clr;
    logic             alarm;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             err;
    logic [CNT_W-1:0] event_count;
    logic [CNT_W-1:0] alarm_cycles;
    modport master (
        output in_valid, greater, equal, lesser, clr,
        input  alarm, rise_pulse, fall_pulse, err, event_count, alarm_cycles
    );
    modport slave (
        input  in_valid, greater, equal, lesser, clr,
        output alarm, rise_pulse, fall_pulse, err, event_count, alarm_cycles
    );
endinterface

// File: rtl/compare_event_fsm_sat_counter.sv
// sat_counter: saturating up-counter; a clear coinciding with an increment leaves the count at 1.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= WIDTH'(inc);
        else if (inc && count != '1)
            count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/compare_event_fsm.sv
// compare_event_fsm: hysteresis alarm over one-hot comparator results with edge pulses and event counter.
// Optional alarm_cycles statistics counter enabled by COMPARE_EVENT_STATS_EN.
module compare_event_fsm
    import compare_event_fsm_pkg::*;
#(
    parameter int HOLD    = HOLD_DEF,
    parameter int RELEASE = RELEASE_DEF,
    parameter int CNT_W   = 8
) (
    input logic           clk,
    input logic           rst,
    compare_event_if.slave bus
);
    localparam logic [7:0] HOLD8 = 8'(HOLD);
    localparam logic [7:0] REL8  = 8'(RELEASE);

    state_t     state, state_n;
    logic [7:0] run, run_n, run_inc;
    logic       valid, bad, rise;

    assign valid   = bus.in_valid && one_hot3(bus.greater, bus.equal, bus.lesser);
    assign bad     = bus.in_valid && !one_hot3(bus.greater, bus.equal, bus.lesser);
    assign run_inc = run + 8'd1;
    // alarm is high in ALARM and RELEASING, i.e. state bit 1
    assign bus.alarm = state[1];
    assign rise      = !state[1] && state_n[1];

    always_comb begin
        state_n = state;
        run_n   = run;
        if (valid) begin
            case (state)
                IDLE: if (bus.greater) begin
                    state_n = (HOLD == 1) ? ALARM : ARMING;
                    run_n   = (HOLD == 1) ? 8'd0 : 8'd1;
                end
                ARMING: if (bus.greater) begin
                    state_n = (run_inc == HOLD8) ? ALARM : ARMING;
                    run_n   = (run_inc == HOLD8) ? 8'd0 : run_inc;
                end else if (bus.lesser) begin
                    state_n = IDLE;
                    run_n   = 8'd0;
                end
                ALARM: if (bus.lesser) begin
                    state_n = (RELEASE == 1) ? IDLE : RELEASING;
                    run_n   = (RELEASE == 1) ? 8'd0 : 8'd1;
                end
                RELEASING: if (bus.lesser) begin
                    state_n = (run_inc == REL8) ? IDLE : RELEASING;
                    run_n   = (run_inc == REL8) ? 8'd0 : run_inc;
                end else if (bus.greater) begin
                    state_n = ALARM;
                    run_n   = 8'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            run            <= 8'd0;
            bus.rise_pulse <= 1'b0;
            bus.fall_pulse <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            state          <= state_n;
            run            <= run_n;
            bus.rise_pulse <= rise;
            bus.fall_pulse <= state[1] && !state_n[1];
            // a new error outranks a simultaneous clear
            bus.err        <= bad ? 1'b1 : (bus.clr ? 1'b0 : bus.err);
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_event_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr),
        .inc   (rise),
        .count (bus.event_count)
    );

`ifdef COMPARE_EVENT_STATS_EN
    sat_counter #(.WIDTH(CNT_W)) u_alarm_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr),
        .inc   (state[1]),
        .count (bus.alarm_cycles)
    );
`else
    assign bus.alarm_cycles = '0;
`endif
endmodule

// File: tb/tb_compare_event_fsm.sv
// tb_compare_event_fsm: directed tests for compare_event_fsm (HOLD=4, RELEASE=2; CNT_W=8 and CNT_W=2 instances).
module tb_compare_event_fsm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, clr = 1'b0;
    logic [2:0] flags = 3'b000;
    int checks = 0;
    int fails = 0;

    localparam logic [2:0] G = 3'b100, E = 3'b010, L = 3'b001;

    always #5 clk = ~clk;

    compare_event_if #(.CNT_W(8)) b0 ();
    compare_event_if #(.CNT_W(2)) b1 ();

    assign b0.in_valid = in_valid;
    assign b0.greater  = flags[2];
    assign b0.equal    = flags[1];
    assign b0.lesser   = flags[0];
    assign b0.clr      = clr;
    assign b1.in_valid = in_valid;
    assign b1.greater  = flags[2];
    assign b1.equal    = flags[1];
    assign b1.lesser   = flags[0];
    assign b1.clr      = clr;

    compare_event_fsm #(.HOLD(4), .RELEASE(2), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b0));
    compare_event_fsm #(.HOLD(4), .RELEASE(2), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(b1));

    task automatic step(input logic v, input logic [2:0] f, input logic c);
        @(negedge clk);
        in_valid = v;
        flags    = f;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        clr = 1'b0;
        flags = 3'b000;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (b0.alarm !== 1'b0) begin fails++; $display("FAIL reset_alarm got=%b exp=0", b0.alarm); end
        checks++; if (b0.rise_pulse !== 1'b0 || b0.fall_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulses got=%b%b exp=00", b0.rise_pulse, b0.fall_pulse); end
        checks++; if (b0.event_count !== 8'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", b0.event_count); end
        checks++; if (b0.err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", b0.err); end
        checks++; if (b0.alarm_cycles !== 8'd0) begin fails++; $display("FAIL reset_alarm_cycles got=%0d exp=0", b0.alarm_cycles); end
        release_reset();
    endtask

    task automatic test_entry();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, G, 1'b0);
            checks++; if (b0.alarm !== 1'b0) begin fails++; $display("FAIL entry_arming%0d got=%b exp=0", i, b0.alarm); end
        end
        step(1'b1, G, 1'b0);
        checks++; if (b0.alarm !== 1'b1) begin fails++; $display("FAIL entry_alarm got=%b exp=1", b0.alarm); end
        checks++; if (b0.rise_pulse !== 1'b1) begin fails++; $display("FAIL entry_rise got=%b exp=1", b0.rise_pulse); end
        checks++; if (b0.event_count !== 8'd1) begin fails++; $display("FAIL entry_count got=%0d exp=1", b0.event_count); end
        step(1'b0, G, 1'b0);
        checks++; if (b0.rise_pulse !== 1'b0) begin fails++; $display("FAIL entry_rise_once got=%b exp=0", b0.rise_pulse); end
        step(1'b1, G, 1'b0);
        step(1'b1, G, 1'b0);
        step(1'b1, L, 1'b0);
        checks++; if (b0.alarm !== 1'b1 || b0.fall_pulse !== 1'b0) begin fails++; $display("FAIL entry_reassert got=%b/%b exp=1/0", b0.alarm, b0.fall_pulse); end
        checks++; if (b0.event_count !== 8'd1) begin fails++; $display("FAIL entry_count_hold got=%0d exp=1", b0.event_count); end
    endtask

    task automatic test_interrupted();
        logic seen;
        do_reset();
        release_reset();
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i == 3) ? L : G, 1'b0);
            seen = seen | b0.alarm;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL interrupted_alarm got=%b exp=0", seen); end
        checks++; if (b0.event_count !== 8'd0) begin fails++; $display("FAIL interrupted_count got=%0d exp=0", b0.event_count); end
        step(1'b1, G, 1'b0);
        checks++; if (b0.alarm !== 1'b1 || b0.event_count !== 8'd1) begin fails++; $display("FAIL interrupted_final got=%b/%0d exp=1/1", b0.alarm, b0.event_count); end
    endtask

    task automatic test_deadband();
        do_reset();
        release_reset();
        step(1'b1, G, 1'b0);
        step(1'b1, G, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, E, 1'b0);
        step(1'b1, G, 1'b0);
        checks++; if (b0.alarm !== 1'b0) begin fails++; $display("FAIL deadband_run3 got=%b exp=0", b0.alarm); end
        step(1'b1, G, 1'b0);
        checks++; if (b0.alarm !== 1'b1) begin fails++; $display("FAIL deadband_alarm got=%b exp=1", b0.alarm); end
        step(1'b1, L, 1'b0);
        step(1'b1, E, 1'b0);
        checks++; if (b0.alarm !== 1'b1) begin fails++; $display("FAIL release_hold got=%b exp=1", b0.alarm); end
        step(1'b1, L, 1'b0);
        checks++; if (b0.alarm !== 1'b0 || b0.fall_pulse !== 1'b1) begin fails++; $display("FAIL release_fall got=%b/%b exp=0/1", b0.alarm, b0.fall_pulse); end
        step(1'b0, L, 1'b0);
        checks++; if (b0.fall_pulse !== 1'b0) begin fails++; $display("FAIL release_fall_once got=%b exp=0", b0.fall_pulse); end
    endtask

    task automatic test_error();
        do_reset();
        release_reset();
        step(1'b0, 3'b110, 1'b0);
        checks++; if (b0.err !== 1'b0) begin fails++; $display("FAIL err_unqualified got=%b exp=0", b0.err); end
        step(1'b1, G, 1'b0);
        step(1'b1, G, 1'b0);
        step(1'b1, 3'b110, 1'b0);
        checks++; if (b0.err !== 1'b1 || b0.alarm !== 1'b0) begin fails++; $display("FAIL err_set got=%b/%b exp=1/0", b0.err, b0.alarm); end
        step(1'b1, G, 1'b0);
        checks++; if (b0.alarm !== 1'b0) begin fails++; $display("FAIL err_run3 got=%b exp=0", b0.alarm); end
        step(1'b1, G, 1'b0);
        checks++; if (b0.alarm !== 1'b1) begin fails++; $display("FAIL err_run_held got=%b exp=1", b0.alarm); end
        step(1'b1, 3'b000, 1'b1);
        checks++; if (b0.err !== 1'b1) begin fails++; $display("FAIL err_clr_collide got=%b exp=1", b0.err); end
        step(1'b0, 3'b000, 1'b1);
        checks++; if (b0.err !== 1'b0 || b0.event_count !== 8'd0) begin fails++; $display("FAIL err_clr got=%b/%0d exp=0/0", b0.err, b0.event_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        release_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) step(1'b1, G, 1'b0);
            step(1'b1, L, 1'b0);
            step(1'b1, L, 1'b0);
        end
        checks++; if (b1.event_count !== 2'd3) begin fails++; $display("FAIL sat_count got=%0d exp=3", b1.event_count); end
        checks++; if (b0.event_count !== 8'd5) begin fails++; $display("FAIL wide_count got=%0d exp=5", b0.event_count); end
    endtask

    task automatic test_collision();
        do_reset();
        release_reset();
        for (int i = 0; i < 4; i++) step(1'b1, G, 1'b0);
        step(1'b1, L, 1'b0);
        do_reset();
        checks++; if (b0.alarm !== 1'b0 || b0.fall_pulse !== 1'b0 || b0.event_count !== 8'd0) begin fails++; $display("FAIL rst_mid_release got=%b/%b/%0d exp=0/0/0", b0.alarm, b0.fall_pulse, b0.event_count); end
        release_reset();
        for (int i = 0; i < 3; i++) step(1'b1, G, 1'b0);
        step(1'b1, G, 1'b1);
        checks++; if (b0.event_count !== 8'd1 || b0.rise_pulse !== 1'b1) begin fails++; $display("FAIL clr_rise got=%0d/%b exp=1/1", b0.event_count, b0.rise_pulse); end
        for (int i = 0; i < 6; i++) step(1'b0, G, 1'b0);
`ifdef COMPARE_EVENT_STATS_EN
        checks++; if (b0.alarm_cycles !== 8'd6) begin fails++; $display("FAIL alarm_cycles got=%0d exp=6", b0.alarm_cycles); end
        step(1'b0, G, 1'b1);
        checks++; if (b0.alarm_cycles !== 8'd1) begin fails++; $display("FAIL alarm_cycles_clr got=%0d exp=1", b0.alarm_cycles); end
`else
        checks++; if (b0.alarm_cycles !== 8'd0) begin fails++; $display("FAIL alarm_cycles_off got=%0d exp=0", b0.alarm_cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_entry();
        test_interrupted();
        test_deadband();
        test_error();
        test_saturation();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
